bram_read_stream: RTL and testbench



---
 rtl/bram_read_stream.sv | 95 +++++++++
 tb/tb_bram_read_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_stream.sv
// -----------------------------------------------------------------------------
// bram_read_stream
//
// Read-port front-end for a dual-port byte-enable block RAM. Converts a
// valid/ready read-request stream into RAM read strobes, captures the RAM's
// registered read data one cycle later and presents it as a valid/ready
// response stream through a 2-entry buffer, so the consumer may stall.
// Requests whose address matches a same-cycle RAM write are held off, because
// the RAM returns undefined data on a read-during-write to the same address.
//
// Ports:
//   CLK          clock, all state updates on posedge
//   RESET        asynchronous, active-high reset
//   REQ_VALID    read request present
//   REQ_READY    request accepted when high together with REQ_VALID
//   REQ_ADDR     word address to read
//   RESP_VALID   RESP_DATA holds a response
//   RESP_READY   consumer takes the response this cycle
//   RESP_DATA    read data, in request order
//   RAM_RE       RAM read enable
//   RAM_RD_ADDR  RAM read address
//   RAM_DO       RAM data out, valid the cycle after RAM_RE
//   RAM_WE       copy of the RAM write enable
//   RAM_WR_ADDR  copy of the RAM write address
// -----------------------------------------------------------------------------
module bram_read_stream #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic                  RAM_RE,
    output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
    input  logic [DATA_WIDTH-1:0] RAM_DO,
    input  logic                  RAM_WE,
    input  logic [ADDR_WIDTH-1:0] RAM_WR_ADDR
);

    // Control state: read in flight, buffer occupancy and pointers.
    logic        vld_p1;
    logic [1:0]  occ;
    logic        wr_ptr;
    logic        rd_ptr;

    // Data buffer is not reset; RESP_DATA is masked while empty instead.
    logic [DATA_WIDTH-1:0] fifo [0:1];

    logic       collide;
    logic       pop;
    logic       issue;
    logic [2:0] used;

    assign collide = RAM_WE && (RAM_WR_ADDR == REQ_ADDR);
    assign pop     = RESP_VALID && RESP_READY;

    // Credits still claimed after this cycle's pop. occ >= pop whenever pop
    // is high, so this never underflows.
    assign used = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};

    assign REQ_READY   = !RESET && !collide && (used < 3'd2);
    assign issue       = REQ_VALID && REQ_READY;
    assign RAM_RE      = issue;
    assign RAM_RD_ADDR = REQ_ADDR;

    assign RESP_VALID = (occ != 2'd0);
    assign RESP_DATA  = (occ != 2'd0) ? fifo[rd_ptr] : '0;

    // Stage p0 -> p1: request issued to the RAM, data returns next cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_p1 <= 1'b0;
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            vld_p1 <= issue;
            occ    <= used[1:0];
            if (vld_p1) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
        end
    end

    // Stage p1 -> buffer: capture RAM_DO only in the cycle after a read, since
    // the RAM holds its output while RE is low.
    always_ff @(posedge CLK) begin
        if (vld_p1) fifo[wr_ptr] <= RAM_DO;
    end

endmodule

// File: tb/tb_bram_read_stream.sv
module tb_bram_read_stream;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          ram_re;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_do;
    logic          ram_we;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_di;

    bram_read_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_ADDR   (req_addr),
        .RESP_VALID (resp_valid),
        .RESP_READY (resp_ready),
        .RESP_DATA  (resp_data),
        .RAM_RE     (ram_re),
        .RAM_RD_ADDR(ram_rd_addr),
        .RAM_DO     (ram_do),
        .RAM_WE     (ram_we),
        .RAM_WR_ADDR(ram_wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural block RAM: registered read, undefined-looking data on a
    // same-address read-during-write, output held while RE is low.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_re)
            ram_do <= (ram_we && ram_wr_addr == ram_rd_addr) ? 32'hBADBAD00 : mem[ram_rd_addr];
        if (ram_we)
            mem[ram_wr_addr] <= ram_di;
    end

    // Reference model: list of accepted, not yet consumed reads.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;
    ent_t q[$];
    int   cyc;
    logic acc;
    logic obs_ready;
    logic obs_re;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Evaluate one cycle at the negedge: compare against the model, then
    // advance the model as the clock edge will.
    task automatic model_eval();
        logic collide, exp_valid, exp_pop, exp_ready;
        collide   = ram_we && (ram_wr_addr == req_addr);
        exp_valid = (q.size() > 0) && ((cyc - q[0].t) >= 2);
        exp_pop   = exp_valid && resp_ready;
        exp_ready = !collide && ((q.size() - int'(exp_pop)) < 2);
        chk("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
        chk("ram_re", {63'd0, ram_re}, {63'd0, req_valid && exp_ready});
        if (req_valid && exp_ready)
            chk("ram_rd_addr", {54'd0, ram_rd_addr}, {54'd0, req_addr});
        chk("resp_valid", {63'd0, resp_valid}, {63'd0, exp_valid});
        if (exp_valid)
            chk("resp_data", {32'd0, resp_data}, {32'd0, q[0].d});
        acc       = req_valid && exp_ready;
        obs_ready = req_ready;
        obs_re    = ram_re;
        if (exp_pop) void'(q.pop_front());
        if (acc) q.push_back('{mem[req_addr], cyc});
        cyc++;
    endtask

    task automatic step(input logic v, input logic [AW-1:0] a, input logic rr,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] di);
        req_valid   = v;
        req_addr    = a;
        resp_ready  = rr;
        ram_we      = we;
        ram_wr_addr = wa;
        ram_di      = di;
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;
        logic v, rr, we;
        logic [AW-1:0] wa;
        logic last_acc;

        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        acc = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] <= $urandom;
        mem[5] <= 32'hDEADBEEF;
        rst = 1'b1;
        req_valid = 1'b1;
        req_addr = '0;
        resp_ready = 1'b1;
        ram_we = 1'b0;
        ram_wr_addr = '0;
        ram_di = '0;

        // Reset state.
        #2;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_ram_re", {63'd0, ram_re}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read with fixed latency 2.
        step(1'b1, 10'd5, 1'b1, 1'b0, '0, '0);
        chk("single_re", {63'd0, obs_re}, 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("single_valid", {63'd0, resp_valid}, 64'd1);
        chk("single_data", {32'd0, resp_data}, 64'hDEADBEEF);
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("single_popped", {63'd0, resp_valid}, 64'd0);

        // Streaming 0..7 back to back.
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, AW'(i), 1'b1, 1'b0, '0, '0);
            if (acc) n++;
        end
        chk("stream_accepts", 64'(n), 64'd8);
        idle(4);

        // Backpressure: two accepts, then ready low until the consumer wakes.
        n = 0;
        a = 10'd20;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, a, 1'b0, 1'b0, '0, '0);
            if (acc) begin
                n++;
                a++;
            end
        end
        chk("bp_accepts", 64'(n), 64'd2);
        chk("bp_stalled", {63'd0, obs_ready}, 64'd0);
        step(1'b1, a, 1'b1, 1'b0, '0, '0);
        chk("bp_release_ready", {63'd0, obs_ready}, 64'd1);
        idle(5);

        // Same-address write collides; a different address does not.
        step(1'b1, 10'd3, 1'b1, 1'b1, 10'd3, 32'h12345678);
        chk("coll_ready", {63'd0, obs_ready}, 64'd0);
        chk("coll_re", {63'd0, obs_re}, 64'd0);
        step(1'b1, 10'd3, 1'b1, 1'b0, '0, '0);
        chk("coll_issue", {63'd0, obs_re}, 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("coll_data", {32'd0, resp_data}, 64'h12345678);
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 10'd3, 1'b1, 1'b1, 10'd4, 32'h0000AAAA);
        chk("nocoll_ready", {63'd0, obs_ready}, 64'd1);
        idle(4);

        // Reset with one response buffered and one read in flight.
        step(1'b1, 10'd30, 1'b0, 1'b0, '0, '0);
        step(1'b1, 10'd31, 1'b0, 1'b0, '0, '0);
        req_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("mrst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("mrst_ram_re", {63'd0, ram_re}, 64'd0);
        chk("mrst_resp_data", {32'd0, resp_data}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        idle(3);
        chk("post_rst_quiet", {63'd0, resp_valid}, 64'd0);
        step(1'b1, 10'd5, 1'b1, 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("post_rst_data", {32'd0, resp_data}, 64'hDEADBEEF);
        idle(2);

        // Randomized traffic on a small address range to provoke collisions.
        v = 1'b0;
        a = '0;
        last_acc = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!v || last_acc) begin
                v = ($urandom_range(0, 3) != 0);
                a = AW'($urandom_range(0, 7));
            end
            rr = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) == 0);
            wa = AW'($urandom_range(0, 7));
            step(v, a, rr, we, wa, $urandom);
            last_acc = acc;
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
